// File: rtl/rv8u_wb_pkg.sv
// ============================================================================
// Package : rv8u_wb_pkg
// Shared constants, write-source encoding and queue entry type for reg_writeback.
// Revision: 1.0
// ============================================================================
`default_nettype none

package rv8u_wb_pkg;

  localparam int WB_BITS  = 8;
  localparam int WB_RBITS = 3;

  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_ALU  = 2'd1,
    WB_SRC_LD   = 2'd2
  } wb_src_e;

  typedef struct packed {
    logic [WB_RBITS-1:0] rd;
    logic [WB_BITS-1:0]  data;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// ============================================================================
// Module  : wb_fifo
// Synchronous FIFO, power-of-two depth, extra pointer bit distinguishes full/empty.
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_writeback.sv
// ============================================================================
// Module  : reg_writeback
// ALU/load write arbitration, load FIFO, pending-load scoreboard, registered
// write port. Optional macro WB_LOAD_BYPASS_EN lets a load skip an empty FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_writeback
  import rv8u_wb_pkg::*;
#(
  parameter int BITS     = WB_BITS,
  parameter int RBITS    = WB_RBITS,
  parameter int LQ_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [RBITS-1:0]      alu_rd,
  input  logic [BITS-1:0]       alu_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [RBITS-1:0]      ld_rd,
  input  logic [BITS-1:0]       ld_data,
  input  logic                  issue_set,
  input  logic [RBITS-1:0]      issue_rd,
  output logic [(1<<RBITS)-1:0] busy,
  output logic                  we,
  output logic [RBITS-1:0]      rd,
  output logic [BITS-1:0]       rd_din
);

  localparam int                NREG    = 1 << RBITS;
  localparam int                EW      = RBITS + BITS;
  localparam logic [NREG-1:0]   R0_MASK = NREG'(1);

  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;
  logic            bypass;
  logic [EW-1:0]   fifo_dout;
  wb_src_e         src;
  logic [RBITS-1:0] wr_idx;
  logic [BITS-1:0] wr_data;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;
  logic [NREG-1:0] busy_r;

  assign alu_ready = run;
  assign ld_ready  = run & ~fifo_full;

`ifdef WB_LOAD_BYPASS_EN
  // An ALU result in the same cycle owns the write port, so the load queues.
  assign bypass = ld_valid & ld_ready & fifo_empty & ~alu_valid;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push = ld_valid & ld_ready & ~bypass;
  assign fifo_pop  = run & ~alu_valid & ~fifo_empty;

  wb_fifo #(
    .WIDTH (EW),
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   ({ld_rd, ld_data}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    src     = WB_SRC_NONE;
    wr_idx  = '0;
    wr_data = '0;
    if (run && alu_valid) begin
      src     = WB_SRC_ALU;
      wr_idx  = alu_rd;
      wr_data = alu_data;
    end else if (fifo_pop) begin
      src     = WB_SRC_LD;
      wr_idx  = fifo_dout[EW-1:BITS];
      wr_data = fifo_dout[BITS-1:0];
    end else if (bypass) begin
      src     = WB_SRC_LD;
      wr_idx  = ld_rd;
      wr_data = ld_data;
    end
  end

  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (src == WB_SRC_LD)    clr_mask = R0_MASK << wr_idx;
    if (issue_set && run)    set_mask = R0_MASK << issue_rd;
  end

  // OR-ing the set after the clear makes a same-edge issue win over the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= '0;
    end else begin
      busy_r <= ((busy_r & ~clr_mask) | set_mask) & ~R0_MASK;
    end
  end

  assign busy = busy_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we     <= 1'b0;
      rd     <= '0;
      rd_din <= '0;
    end else begin
      we <= 1'b0;
      if (src != WB_SRC_NONE) begin
        we     <= (wr_idx != '0);
        rd     <= wr_idx;
        rd_din <= wr_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/reg_writeback.md
# reg_writeback

Write-side front end of the 8-bit core's register file: accepts results from the ALU and the load unit over valid/ready handshakes, buffers load results in a small FIFO, and drives the register file's registered write port (`we`/`rd`/`rd_din`). It also keeps a per-register pending-load scoreboard that the decoder uses to stall on outstanding loads. It sits between the execute/load units and the register file.

## Interface
- `BITS`, 8, data width.
- `RBITS`, 3, register index width; 2**RBITS registers, index 0 hard-wired zero.
- `LQ_DEPTH`, 2, load FIFO depth; must be a power of two, 2 or more.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `run`  in  1  core run enable; 0 freezes the block.
- `alu_valid`  in  1  ALU result valid.
- `alu_ready`  out  1  ALU result accepted; combinational, equals `run`.
- `alu_rd`  in  RBITS  ALU destination.
- `alu_data`  in  BITS  ALU result.
- `ld_valid`  in  1  load result valid.
- `ld_ready`  out  1  combinational, `run & !full`.
- `ld_rd`  in  RBITS  load destination.
- `ld_data`  in  BITS  load data.
- `issue_set`  in  1  a load is being issued; mark `issue_rd` pending.
- `issue_rd`  in  RBITS  destination of the issued load.
- `busy`  out  2**RBITS  pending-load bit per register; bit 0 is constant 0.
- `we`  out  1  register-file write enable, registered.
- `rd`  out  RBITS  write index, registered.
- `rd_din`  out  BITS  write data, registered.

## Operation
- A handshake completes when valid and ready are both high at a rising edge.
- The load path enqueues into the FIFO `{ld_rd, ld_data}`.
- The ALU has priority. Each cycle with `run=1`:
  - If `alu_valid` is high, the ALU result is written.
  - Otherwise, if the FIFO is non-empty, the head is dequeued and written.
  - Otherwise no write occurs.
- Write register: on the selected source, `we<=1`, `rd<=index`, `rd_din<=data`. With no source, `we<=0`, and `rd`/`rd_din` hold their values.
- Writes with index 0 are accepted and consumed, but `we` stays 0.
- Scoreboard:
  - `issue_set & run & issue_rd!=0` sets `busy[issue_rd]`.
  - A load-path write to register r clears `busy[r]` on the same edge that asserts `we`.
  - If set and clear hit the same r on one edge, the set wins.
  - ALU writes never touch `busy`.
- FIFO: simultaneous enqueue and dequeue while full is not possible, because `ld_ready` is low when full. When non-full, simultaneous enqueue and dequeue leaves the count unchanged. Pointers wrap modulo `LQ_DEPTH`.
- `run=0`:
  - `alu_ready=0`, `ld_ready=0`, no dequeue.
  - `we<=0` at the next edge.
  - `issue_set` is ignored.
  - FIFO and `busy` contents hold.
- Reset, async on `rst_n=0`:
  - `we=0`, `rd=0`, `rd_din=0`, `busy=0`, FIFO empty.
  - Combinational outputs follow `run`.
  - Reset during a pending write drops the write, and the FIFO contents are lost.

## Timing
- ALU latency: accepted at edge N, so `we=1` in the cycle after N.
- Load latency: enqueued at edge N, dequeued at edge N+1 at the earliest, so `we=1` after N+1 (2 cycles).
- A continuous stream of ALU results starves the load FIFO. The decoder guarantees gaps through the scoreboard stall.
- `busy[r]` falls in the same cycle that `we` rises for the load to r.

## Configuration
- `WB_LOAD_BYPASS_EN` defined:
  - A load accepted at edge N, with the FIFO empty and `alu_valid=0`, bypasses the FIFO and is written at edge N, so load latency becomes 1 cycle.
  - The `busy` clear happens on that same edge.
  - An ALU result arriving in the same cycle still blocks the bypass, and the load is enqueued normally.
- `WB_LOAD_BYPASS_EN` undefined: no bypass; behaviour is exactly as specified under Operation.

## Structure
- Package `rv8u_wb_pkg`:
  - Default `BITS`/`RBITS` constants.
  - Write-source enum `WB_SRC_NONE`, `WB_SRC_ALU`, `WB_SRC_LD`.
  - Entry struct `{rd, data}`.
- Sub-module `wb_fifo`: a parameterised synchronous FIFO with push, pop, full, empty, and an async active-low reset.
- Arbitration, scoreboard and write register live in `reg_writeback`.

## Test plan
- Reset, then ALU writes r3=0x5A at edge 1 -> `we=1`, `rd=3`, `rd_din=0x5A` after edge 1, and `we=0` after edge 2.
- `issue_set` r5, then load r5=0xC3 with the ALU idle -> `busy[5]=1` until `we` rises; write occurs 2 cycles after the handshake (1 cycle with `WB_LOAD_BYPASS_EN`).
- Two loads (r1=0x11, r2=0x22) while the ALU is valid for 3 cycles -> `ld_ready` drops after 2 accepts; ALU writes first, then r1, then r2 in order.
- Load to r0 and ALU to r0 -> both handshakes complete and `we` stays 0.
- Set `issue_set` r4 on the same edge that a load writes r4 -> `busy[4]` remains 1.
- `run=0` with the FIFO holding one entry, then `rst_n` pulsed low mid-cycle -> no `we` while halted; after reset `busy=0`, the FIFO is empty and `we=0`.
